// File: rtl/oc_ascii_hex_rx.sv
// oc_ascii_hex_rx: parses delimiter-separated ASCII hex tokens into numeric results
module oc_ascii_hex_rx #(
    parameter int Width     = 32,
    parameter int MaxDigits = Width / 4
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [7:0]                     in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [Width-1:0]               out_data,
    output logic [$clog2(MaxDigits+1)-1:0] out_digits,
    output logic                           out_error,
    output logic                           out_valid,
    input  logic                           out_ready
);
    localparam int CW = $clog2(MaxDigits + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, SKIP, HOLD} state_t;

    state_t           state;
    logic             run;
    logic [Width-1:0] acc;
    logic [CW-1:0]    count;
    logic             is_num;
    logic             is_alpha;
    logic             is_digit;
    logic             is_delim;
    logic             is_esc;
    logic             is_nul;
    logic [3:0]       nibble;
    logic             take;

    assign is_num   = in_data >= 8'h30 && in_data <= 8'h39;
    assign is_alpha = (in_data >= 8'h41 && in_data <= 8'h46) || (in_data >= 8'h61 && in_data <= 8'h66);
    assign is_digit = is_num || is_alpha;
    assign is_delim = in_data == 8'h20 || in_data == 8'h0d || in_data == 8'h0a;
    assign is_esc   = in_data == 8'h1b;
    assign is_nul   = in_data == 8'h00;
    assign nibble   = in_data[3:0] + (is_alpha ? 4'd9 : 4'd0);
    assign in_ready = run && state != HOLD;
    assign take     = in_valid && in_ready;

    // reset release is retimed to the clock; nothing is accepted until it goes high
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) run <= 1'b0;
        else          run <= 1'b1;
    end

    // token parser: accumulate digits, flag bad tokens, present one result per token
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            acc        <= '0;
            count      <= '0;
            out_data   <= '0;
            out_digits <= '0;
            out_error  <= 1'b0;
            out_valid  <= 1'b0;
        end else if (state == HOLD) begin
            if (out_ready) begin
                out_valid <= 1'b0;
                acc       <= '0;
                count     <= '0;
                state     <= IDLE;
            end
        end else if (take) begin
            if (is_esc) begin
                acc   <= '0;
                count <= '0;
                state <= IDLE;
            end else if (is_delim) begin
                if (state == ACCUM) begin
                    out_data   <= acc;
                    out_digits <= count;
                    out_error  <= 1'b0;
                    out_valid  <= 1'b1;
                    state      <= HOLD;
                end else if (state == SKIP) begin
                    out_data   <= '0;
                    out_digits <= '0;
                    out_error  <= 1'b1;
                    out_valid  <= 1'b1;
                    state      <= HOLD;
                end
            end else if (is_digit && state != SKIP) begin
                if (count == CW'(MaxDigits)) begin
                    state <= SKIP;
                end else begin
                    acc   <= (acc << 4) | Width'(nibble);
                    count <= count + 1'b1;
                    state <= ACCUM;
                end
            end else if (!is_digit && !is_nul && state != SKIP) begin
                state <= SKIP;
            end
        end
    end

`ifndef SYNTHESIS
    // an offered character must be fully defined
    always @(posedge clock) begin
        if (reset_n && in_valid) assert (!$isunknown(in_data)) else $error("in_data has X/Z while in_valid");
    end
`endif

endmodule

// File: tb/tb_oc_ascii_hex_rx.sv
// tb_oc_ascii_hex_rx: randomized and directed checks of the hex token parser against a token-level model
module tb_oc_ascii_hex_rx;
    localparam int W    = 32;
    localparam int MAXD = 8;

    typedef struct {
        logic [31:0] d;
        int          n;
        logic        e;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_digits;
    logic        out_error;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int   vectors = 0;
    int   errors = 0;
    int   n_res = 0;
    bit   rnd_rdy = 0;
    exp_t exp_q[$];
    logic [7:0] tok[$];
    bit   bad = 0;
    exp_t r_m;
    bit   held = 0;
    logic [31:0] hd;
    logic [3:0]  hn;
    logic        he;

    oc_ascii_hex_rx #(.Width(W), .MaxDigits(MAXD)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_digits (out_digits),
        .out_error  (out_error),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
    endfunction

    function automatic int hex_val(input logic [7:0] c);
        if (c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h61) return int'(c) - 97 + 10;
        return int'(c) - 65 + 10;
    endfunction

    task automatic model_reset();
        tok.delete();
        exp_q.delete();
        bad = 0;
    endtask

    // token-level reference: collect digits as text, evaluate only at the delimiter
    task automatic model_char(input logic [7:0] c);
        logic [31:0] v;
        if (c == 8'h00) return;
        if (c == 8'h1b) begin
            tok.delete();
            bad = 0;
        end else if (c == 8'h20 || c == 8'h0d || c == 8'h0a) begin
            if (bad) begin
                exp_q.push_back('{32'h0, 0, 1'b1});
            end else if (tok.size() > 0) begin
                v = 0;
                foreach (tok[i]) v = v * 16 + 32'(hex_val(tok[i]));
                exp_q.push_back('{v, tok.size(), 1'b0});
            end
            tok.delete();
            bad = 0;
        end else if (is_hex(c) && !bad && tok.size() < MAXD) begin
            tok.push_back(c);
        end else begin
            bad = 1;
        end
    endtask

    // called just after a rising edge; returns just after the edge that took the character
    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        in_data = c;
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && n < 100) begin
            @(posedge clock); #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            n++;
        end
        if (!in_ready) check("ready_timeout", {63'h0, in_ready}, 64'h1);
        else model_char(c);
        @(posedge clock); #1;
        in_valid = 1'b0;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    // scoreboard: every handshake consumes one modelled result; held results must not move
    always @(negedge clock) begin
        if (reset_n && out_valid) begin
            if (held) begin
                check("stable_data", out_data, hd);
                check("stable_digits", out_digits, hn);
                check("stable_error", out_error, he);
            end
            if (out_ready) begin
                n_res++;
                if (exp_q.size() == 0) begin
                    check("spurious_result", {63'h0, out_valid}, 64'h0);
                end else begin
                    r_m = exp_q.pop_front();
                    check("res_data", out_data, r_m.d);
                    check("res_digits", out_digits, r_m.n);
                    check("res_error", out_error, r_m.e);
                end
            end
        end
        held = reset_n && out_valid && !out_ready;
        hd = out_data;
        hn = out_digits;
        he = out_error;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int r;
        string hexs;
        hexs = "0123456789abcdefABCDEF";
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_digits", out_digits, 0);
        check("rst_out_error", out_error, 0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("rel_ready_before_clk", in_ready, 0);
        @(negedge clock);
        check("rel_ready_after_clk", in_ready, 1);
        @(posedge clock); #1;

        base = n_res;
        send_str("1A2f");
        send(8'h0d);
        @(negedge clock);
        check("r032_latency", out_valid, 1);
        check("r032_data", out_data, 32'h1A2F);
        check("r032_digits", out_digits, 4);
        check("r032_error", out_error, 0);
        @(posedge clock); #1;
        idle(3);
        check("r032_count", n_res - base, 1);

        base = n_res;
        send_str("  \n\n7 ");
        idle(3);
        check("r033_count", n_res - base, 1);

        base = n_res;
        send_str("12g4 123456789 ");
        idle(3);
        check("r034_count", n_res - base, 2);

        base = n_res;
        send_str("AB");
        send(8'h1b);
        send_str("CD\n");
        idle(3);
        check("r035_count", n_res - base, 1);

        base = n_res;
        out_ready = 1'b0;
        send_str("5 ");
        in_data = "6";
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clock);
            check("r036_valid", out_valid, 1);
            check("r036_data", out_data, 32'h5);
            check("r036_ready", in_ready, 0);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        send_str("6 ");
        idle(3);
        check("r036_count", n_res - base, 2);

        out_ready = 1'b0;
        send_str("9 ");
        @(negedge clock);
        check("hold_before_rst", out_valid, 1);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("hold_rst_valid", out_valid, 0);
        check("hold_rst_data", out_data, 0);
        check("hold_rst_ready", in_ready, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        idle(1);

        base = n_res;
        send_str("FF");
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("r037_valid", out_valid, 0);
        check("r037_data", out_data, 0);
        check("r037_digits", out_digits, 0);
        check("r037_error", out_error, 0);
        check("r037_ready", in_ready, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle(1);
        send_str("3\r");
        @(negedge clock);
        check("r037_res_data", out_data, 32'h3);
        check("r037_res_digits", out_digits, 1);
        @(posedge clock); #1;
        idle(3);
        check("r037_count", n_res - base, 1);

        rnd_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      send(hexs[$urandom_range(0, 21)]);
            else if (r < 62) send(8'h20);
            else if (r < 68) send(8'h0d);
            else if (r < 74) send(8'h0a);
            else if (r < 78) send(8'h1b);
            else if (r < 83) send(8'h00);
            else             send(8'($urandom_range(1, 255)));
        end
        send(8'h20);
        rnd_rdy = 0;
        out_ready = 1'b1;
        idle(5);
        check("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
